// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed little-endian data RAM controller.
// Supports byte/half/word(/dword) loads with sign or zero extension, byte-lane store
// merge, atomic swap (old data returned, new data written on the same edge), a
// valid/ready request handshake and a configurable number of wait states.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When defined, a misaligned access is
// rejected with resp_err. When undefined, the access is aligned down.
module data_memory_ctrl #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4096,
   parameter int ADDR_W      = $clog2(DEPTH) + $clog2(DATA_W / 8),
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = ADDR_W - OFF_W;
   localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_COMMIT,
      S_RESP
   } state_t;

   state_t              state_q;
   logic                ready_q;
   logic                resp_valid_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic                resp_err_q;
   logic [3:0]          wait_cnt_q;

   // Request fields captured at accept; not reset because they are only data.
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                rd_q;
   logic                wr_q;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [OFF_W-1:0]    mask_d;
   logic [OFF_W-1:0]    off_d;
   logic [IDX_W-1:0]    idx_d;
   logic                size_ok_d;
   logic                err_d;
   logic [DATA_W-1:0]   old_word_d;
   logic [DATA_W-1:0]   merged_d;
   logic [DATA_W-1:0]   load_d;
   logic                accept_d;

   // Right-align the addressed lane and extend it from 8<<size bits to DATA_W.
   function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [1:0]        size,
                                                     input logic              uns);
      logic [DATA_W-1:0]        shifted;
      logic signed [DATA_W-1:0] top;
      int                       nbits;
      int                       pad;
      shifted = word >> (8 * int'(off));
      nbits   = 8 << size;
      if (nbits > DATA_W) nbits = DATA_W;
      pad     = DATA_W - nbits;
      top     = signed'(shifted << pad);
      if (uns) return (shifted << pad) >> pad;
      return top >>> pad;
   endfunction

   // Replace only the addressed bytes of the old word with the low bytes of wdata.
   function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [1:0]        size);
      logic [DATA_W-1:0] res;
      int                lo;
      int                nb;
      res = old;
      lo  = int'(off);
      nb  = 1 << size;
      for (int b = 0; b < BYTES; b++) begin
         if (b >= lo && b < lo + nb) res[8*b +: 8] = wdata[8*(b-lo) +: 8];
      end
      return res;
   endfunction

   // Alignment mask for the captured size; dword wraps to the full offset field.
   always_comb begin
      mask_d = '0;
      case (size_q)
         2'd0:    mask_d = '0;
         2'd1:    mask_d = OFF_W'(1);
         2'd2:    mask_d = OFF_W'(3);
         default: mask_d = OFF_W'(7);
      endcase
   end

   assign accept_d   = req_valid && ready_q && (req_read || req_write);
   assign size_ok_d  = (size_q != 2'd3) || (DATA_W == 64);
   assign off_d      = addr_q[OFF_W-1:0] & ~mask_d;
   assign idx_d      = addr_q[ADDR_W-1:OFF_W];
   assign old_word_d = mem_q[idx_d];
   assign merged_d   = merge_store(old_word_d, wdata_q, off_d, size_q);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign err_d = !size_ok_d || (|(addr_q[OFF_W-1:0] & mask_d));
`else
   assign err_d = !size_ok_d;
`endif

   // Load data returned: old word for loads and swaps, zero for stores and errors.
   always_comb begin
      load_d = '0;
      if (!err_d && rd_q) load_d = extend_load(old_word_d, off_d, size_q, uns_q);
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         wait_cnt_q   <= 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               resp_valid_q <= 1'b0;
               if (accept_d) begin
                  addr_q     <= req_addr;
                  size_q     <= req_size;
                  uns_q      <= req_unsigned;
                  wdata_q    <= req_wdata;
                  rd_q       <= req_read;
                  wr_q       <= req_write;
                  ready_q    <= 1'b0;
                  wait_cnt_q <= 4'd0;
                  state_q    <= (WAIT_STATES > 0) ? S_WAIT : S_COMMIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt_q == WS_LAST) begin
                  wait_cnt_q <= 4'd0;
                  state_q    <= S_COMMIT;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 4'd1;
               end
            end
            S_COMMIT: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= load_d;
               resp_err_q   <= err_d;
               state_q      <= S_RESP;
            end
            default: begin
               resp_valid_q <= 1'b0;
               ready_q      <= 1'b1;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   // Write the merged word on the COMMIT edge; a reset on that edge aborts the write.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_COMMIT && wr_q && !err_d) mem_q[idx_d] <= merged_d;
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
